// File: rtl/disp_pkg.sv
// Shared constants for the 4-digit 7-segment display scheduler:
// mode encodings, snake path, hex segment table.
package disp_pkg;

    typedef enum logic [1:0] {
        ModeAnim = 2'b00,
        ModeShow = 2'b01
    } mode_e;

    typedef enum logic {
        StAnim,
        StShow
    } state_e;

    localparam logic [3:0] LAST_POS = 4'd11;

    // Segment bus bit lit at each snake position, clockwise around the perimeter
    localparam logic [4:0] SNAKE_IDX [0:11] = '{
        5'd27, 5'd20, 5'd13, 5'd6, 5'd5, 5'd4,
        5'd3,  5'd10, 5'd17, 5'd24, 5'd23, 5'd22
    };

    // Active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] HEX7 [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7_decode
    import disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX7[i_nibble];

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: shares the segment bus between an idle snake animation and
// timed hex-value requests, with a one-entry request buffer.
module disp_sched
    import disp_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 12
) (
    input  logic        clock6hz,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic [15:0] i_req_value,
    output logic        o_req_ready,
    input  logic        i_pause,
    output logic [27:0] o_seg,
    output logic        o_busy,
    output logic [1:0]  o_mode
);

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_TICKS - 1);

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_pos, w_pos_nxt;
    logic [7:0]  r_hold, w_hold_nxt;
    logic [15:0] r_cur, w_cur_nxt;
    logic [15:0] r_pend, w_pend_nxt;
    logic        r_pend_v, w_pend_v_nxt;

    logic        w_accept;
    logic [3:0]  w_pos_inc;
    logic [27:0] w_snake;
    logic [27:0] w_digits;

    assign o_req_ready = !r_pend_v;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_pos_inc   = (r_pos == LAST_POS) ? 4'd0 : r_pos + 4'd1;

    always_ff @(posedge clock6hz or negedge reset) begin
        if (!reset) begin
            r_state  <= StAnim;
            r_pos    <= 4'd0;
            r_hold   <= 8'd0;
            r_cur    <= 16'd0;
            r_pend   <= 16'd0;
            r_pend_v <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_hold   <= w_hold_nxt;
            r_cur    <= w_cur_nxt;
            r_pend   <= w_pend_nxt;
            r_pend_v <= w_pend_v_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_hold_nxt   = r_hold;
        w_cur_nxt    = r_cur;
        w_pend_nxt   = r_pend;
        w_pend_v_nxt = r_pend_v;
        unique case (r_state)
            StAnim: begin
                // The snake position is frozen on the accept edge so it resumes in place
                if (w_accept) begin
                    w_state_nxt = StShow;
                    w_cur_nxt   = i_req_value;
                    w_hold_nxt  = HOLD_RELOAD;
                end else if (!i_pause) begin
                    w_pos_nxt = w_pos_inc;
                end
            end
            StShow: begin
                if (i_pause || (r_hold != 8'd0)) begin
                    if (!i_pause) begin
                        w_hold_nxt = r_hold - 8'd1;
                    end
                    if (w_accept) begin
                        w_pend_nxt   = i_req_value;
                        w_pend_v_nxt = 1'b1;
                    end
                end else if (r_pend_v) begin
                    w_cur_nxt    = r_pend;
                    w_pend_v_nxt = 1'b0;
                    w_hold_nxt   = HOLD_RELOAD;
                end else if (w_accept) begin
                    w_cur_nxt  = i_req_value;
                    w_hold_nxt = HOLD_RELOAD;
                end else begin
                    w_state_nxt = StAnim;
                end
            end
            default: w_state_nxt = StAnim;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_digit
        hex7_decode u_hex7 (
            .i_nibble (r_cur[4*g +: 4]),
            .o_seg    (w_digits[7*g +: 7])
        );
    end

    always_comb begin
        w_snake                   = {4{SEG_BLANK}};
        w_snake[SNAKE_IDX[r_pos]] = 1'b0;
        o_busy = (r_state == StShow);
        o_mode = o_busy ? ModeShow : ModeAnim;
        o_seg  = o_busy ? w_digits : w_snake;
    end

endmodule

// File: tb/tb_disp_sched.sv
// Randomized and directed bench for disp_sched against a countdown-based model;
// instance 0 uses the default hold, instance 1 a one-cycle hold.
module tb_disp_sched;

    logic        clock6hz = 1'b0;
    logic        reset;
    logic        in_v   [2];
    logic [15:0] in_val [2];
    logic        in_p   [2];

    logic        rdy0, rdy1, busy0, busy1;
    logic [27:0] seg0, seg1;
    logic [1:0]  mode0, mode1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock6hz = ~clock6hz;

    disp_sched #(.HOLD_TICKS(12)) dut0 (
        .clock6hz    (clock6hz),
        .reset       (reset),
        .i_req_valid (in_v[0]),
        .i_req_value (in_val[0]),
        .o_req_ready (rdy0),
        .i_pause     (in_p[0]),
        .o_seg       (seg0),
        .o_busy      (busy0),
        .o_mode      (mode0)
    );

    disp_sched #(.HOLD_TICKS(1)) dut1 (
        .clock6hz    (clock6hz),
        .reset       (reset),
        .i_req_valid (in_v[1]),
        .i_req_value (in_val[1]),
        .o_req_ready (rdy1),
        .i_pause     (in_p[1]),
        .o_seg       (seg1),
        .o_busy      (busy1),
        .o_mode      (mode1)
    );

    // Reference model: SHOW counts down the remaining edges on screen
    int          holds [2] = '{12, 1};
    int          tb_path [12] = '{27, 20, 13, 6, 5, 4, 3, 10, 17, 24, 23, 22};
    logic [6:0]  tb_hex [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    bit          m_show [2];
    int          m_pos  [2];
    int          m_left [2];
    logic [15:0] m_cur  [2];
    logic [15:0] m_pq   [2];
    bit          m_pn   [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_show[k] = 0; m_pos[k] = 0; m_left[k] = 0;
            m_cur[k]  = 16'd0; m_pq[k] = 16'd0; m_pn[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit acc;
        acc = in_v[k] && !m_pn[k];
        if (!m_show[k]) begin
            if (acc) begin
                m_show[k] = 1; m_cur[k] = in_val[k]; m_left[k] = holds[k];
            end else if (!in_p[k]) begin
                m_pos[k] = (m_pos[k] + 1) % 12;
            end
        end else if (in_p[k]) begin
            if (acc) begin m_pq[k] = in_val[k]; m_pn[k] = 1; end
        end else begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
                if (m_pn[k]) begin
                    m_cur[k] = m_pq[k]; m_pn[k] = 0; m_left[k] = holds[k];
                end else if (acc) begin
                    m_cur[k] = in_val[k]; m_left[k] = holds[k];
                end else begin
                    m_show[k] = 0;
                end
            end else if (acc) begin
                m_pq[k] = in_val[k]; m_pn[k] = 1;
            end
        end
    endtask

    function automatic logic [27:0] exp_seg(input int k);
        logic [27:0] r;
        logic [3:0]  nib;
        if (m_show[k]) begin
            for (int d = 0; d < 4; d++) begin
                nib = m_cur[k][4*d +: 4];
                r[7*d +: 7] = tb_hex[nib];
            end
        end else begin
            r = '1;
            r[tb_path[m_pos[k]]] = 1'b0;
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("seg0",  {4'd0, seg0}, {4'd0, exp_seg(0)});
        check_eq("busy0", {31'd0, busy0}, {31'd0, m_show[0]});
        check_eq("mode0", {30'd0, mode0}, {31'd0, m_show[0]});
        check_eq("rdy0",  {31'd0, rdy0}, {31'd0, !m_pn[0]});
        check_eq("seg1",  {4'd0, seg1}, {4'd0, exp_seg(1)});
        check_eq("busy1", {31'd0, busy1}, {31'd0, m_show[1]});
        check_eq("mode1", {30'd0, mode1}, {31'd0, m_show[1]});
        check_eq("rdy1",  {31'd0, rdy1}, {31'd0, !m_pn[1]});
    endtask

    task automatic cycle();
        @(posedge clock6hz);
        model_step(0);
        model_step(1);
        #1 check_all();
        @(negedge clock6hz);
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            in_v[k] = 1'b0; in_val[k] = 16'd0; in_p[k] = 1'b0;
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        check_eq("rst_seg0",  {4'd0, seg0}, 32'h07FF_FFFF);
        check_eq("rst_busy0", {31'd0, busy0}, 32'd0);
        check_eq("rst_rdy0",  {31'd0, rdy0}, 32'd1);
        @(negedge clock6hz);
        reset = 1'b1;
    endtask

    int  n_busy;
    bit  will_acc;

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clock6hz);
        do_reset();

        // Free-running snake around the full perimeter and back to the start
        repeat (13) cycle();

        // Snake at pos 3, one request, then resume at pos 3
        do_reset();
        repeat (3) cycle();
        in_v[0] = 1'b1; in_val[0] = 16'h1234;
        cycle();
        in_v[0] = 1'b0;
        check_eq("show1234", {4'd0, seg0},
                 {4'd0, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
        repeat (12) cycle();
        check_eq("resume_pos3", {4'd0, seg0}, {4'd0, ~(28'd1 << 6)});

        // Back-to-back on instance 0; bypass on the expiry edge on instance 1
        in_v[0] = 1'b1; in_val[0] = 16'hABCD;
        in_v[1] = 1'b1; in_val[1] = 16'h1111;
        cycle();
        in_v[0] = 1'b0;
        in_val[1] = 16'h2222;
        cycle();
        check_eq("bypass_mode", {30'd0, mode1}, 32'd1);
        check_eq("bypass_rdy", {31'd0, rdy1}, 32'd1);
        in_v[1] = 1'b0;
        in_v[0] = 1'b1; in_val[0] = 16'hEF01;
        cycle();
        check_eq("buf_full_rdy", {31'd0, rdy0}, 32'd0);
        in_val[0] = 16'h5555;
        will_acc = 0;
        for (int i = 0; i < 20; i++) begin
            will_acc = !m_pn[0];
            cycle();
            if (will_acc) break;
        end
        check_eq("third_accepted", {31'd0, will_acc}, 32'd1);
        in_v[0] = 1'b0;
        repeat (30) cycle();

        // Pause for five edges inside SHOW stretches it to 17 edges
        in_v[0] = 1'b1; in_val[0] = 16'h0F0F;
        cycle();
        in_v[0] = 1'b0;
        n_busy = 1;
        for (int i = 0; i < 30; i++) begin
            in_p[0] = (i >= 3 && i < 8);
            cycle();
            if (busy0) n_busy++;
        end
        check_eq("pause_len", n_busy, 17);
        in_p[0] = 1'b1;
        repeat (4) cycle();
        in_p[0] = 1'b0;

        // Reset mid-SHOW with a full buffer; the buffered value must never appear
        in_v[0] = 1'b1; in_val[0] = 16'h9999;
        cycle();
        in_val[0] = 16'h7777;
        cycle();
        in_v[0] = 1'b0;
        do_reset();
        repeat (20) cycle();

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                in_v[k]   = ($urandom_range(3) == 0);
                in_val[k] = 16'($urandom);
                in_p[k]   = ($urandom_range(7) == 0);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
